lsu_wb: RTL and testbench
=========================

# lsu_wb

Load/store and writeback sequencer for the multicycle RISC-V core. It consumes the ALU's per-instruction outputs: result, word memory address, register-write enable and instruction class. It then performs the data-memory transaction over a req/ack handshake and drives the single register-file write port. It sits between the ALU and both data memory and the register file, and signals instruction retirement back to the control FSM.

## Interface
- TIMEOUT_CYCLES, 16, max cycles REQ waits for dmem_ack. Used only with LSU_WB_TIMEOUT_EN. Legal range 1..255.

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle strobe; ALU outputs valid this cycle
- is_l_instr  in  1  load instruction
- is_s_instr  in  1  store instruction
- wr_en  in  1  ALU requests register writeback (I/R/J/JR)
- rd  in  5  destination register index
- alu_result  in  32  writeback data, or store data for stores
- alu_mem_addr  in  12  word address for loads/stores
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle retirement pulse
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  12  word address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  memory accepted/completed the request
- dmem_rdata  in  32  load data, valid when dmem_ack=1
- rf_we  out  1  register-file write strobe
- rf_waddr  out  5  register-file write index
- rf_wdata  out  32  register-file write data
- err  out  1  timeout flag; constant 0 without LSU_WB_TIMEOUT_EN

## Operation
- States: IDLE, REQ, WB, DONE. All outputs decode from registered state and registered data, with no input-to-output combinational paths.
- IDLE: start=1 latches rd, alu_result, alu_mem_addr and the class bits, then:
  - is_l_instr → REQ, we=0.
  - else is_s_instr → REQ, we=1, wdata = latched alu_result.
  - else wr_en → WB.
  - else → DONE.
  - If load and store are both set, the load wins.
- start while busy is ignored; the latched operands do not change.
- REQ:
  - dmem_req=1, with dmem_we/dmem_addr/dmem_wdata held stable until ack.
  - Ack with we=0: capture dmem_rdata as write data, go to WB.
  - Ack with we=1: go to DONE.
  - dmem_ack outside REQ is ignored.
- WB: rf_we=1 for exactly one cycle with rf_waddr/rf_wdata, then DONE. rd=0 suppresses rf_we; the WB cycle is still spent.
- DONE: done=1 for one cycle, then IDLE. A start in this cycle is ignored.

## Timing
- Reset values: every output 0, state IDLE, latched data 0.
- Reset mid-operation aborts immediately. Any outstanding memory request is abandoned, and a late ack is ignored.
- Latency in cycles after the start cycle (cycle 0), with ack on the first REQ cycle:
  - ALU writeback: rf_we at 1, done at 2.
  - Load: req at 1, rf_we at 2, done at 3.
  - Store: req at 1, done at 2.
  - No writeback: done at 1.
- Each extra ack wait cycle adds one cycle to load/store latency.
- Minimum start-to-start spacing is the latency plus 1 (the IDLE cycle).

## Configuration
- LSU_WB_TIMEOUT_EN defined:
  - An 8-bit counter clears on REQ entry and increments each REQ cycle without ack.
  - On the TIMEOUT_CYCLES-th cycle without ack, dmem_req drops, the state goes to DONE, no writeback occurs, and err sets.
  - err is sticky until the next accepted start or reset.
  - Ack on the final cycle counts as success.
- LSU_WB_TIMEOUT_EN undefined: REQ waits indefinitely, the counter is absent, and err is tied to 0.

## Test plan
- ALU op: start, wr_en=1, rd=5, alu_result=0xDEADBEEF → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at cycle 1; done at cycle 2; dmem_req never asserts.
- Load: alu_mem_addr=0x0A4, rd=7; ack after 3 wait cycles with rdata=0x12345678 → dmem_req held 4 cycles with addr 0x0A4 and we=0; then rf_we writes 0x12345678 to r7; done one cycle later.
- Store: addr=0xFFF, alu_result=0xCAFEF00D, ack on the first cycle → one req cycle with we=1 and wdata=0xCAFEF00D; rf_we never asserts; done at cycle 2.
- rd=0 with wr_en=1, plus a second start pulsed during busy → no rf_we; done at cycle 2; the second start does not alter the operation or cause an extra retirement.
- Reset during REQ, then a stray ack → all outputs 0 immediately; the ack is ignored; the next start behaves normally.
- With LSU_WB_TIMEOUT_EN and TIMEOUT_CYCLES=4, a load that never acks → req high exactly 4 cycles; done next cycle with no rf_we; err=1 until the next start.

Source files
------------

// File: rtl/lsu_wb.sv
// Load/store and writeback sequencer: runs one data-memory req/ack transaction and one register-file write per start.
// Optional REQ timeout with a sticky err flag is enabled by defining LSU_WB_TIMEOUT_EN.
module lsu_wb #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_l_instr,
    input  logic        is_s_instr,
    input  logic        wr_en,
    input  logic [4:0]  rd,
    input  logic [31:0] alu_result,
    input  logic [11:0] alu_mem_addr,
    output logic        busy,
    output logic        done,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [11:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("lsu_wb: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic [11:0] addr_q, addr_d;
    logic        we_q, we_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        req_q, req_d;
    logic        mwe_q, mwe_d;
    logic [11:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic        rfwe_q, rfwe_d;
    logic [4:0]  rfwaddr_q, rfwaddr_d;
    logic [31:0] rfwdata_q, rfwdata_d;
    logic        err_q, err_d;

`ifdef LSU_WB_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        data_d  = data_q;
        addr_d  = addr_q;
        we_d    = we_q;
        err_d   = err_q;
`ifdef LSU_WB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_d   = rd;
                    data_d = alu_result;
                    addr_d = alu_mem_addr;
                    err_d  = 1'b0;
`ifdef LSU_WB_TIMEOUT_EN
                    cnt_d  = 8'd0;
`endif
                    // Load takes priority when both class bits are set.
                    if (is_l_instr) begin
                        we_d    = 1'b0;
                        state_d = S_REQ;
                    end else if (is_s_instr) begin
                        we_d    = 1'b1;
                        state_d = S_REQ;
                    end else if (wr_en) begin
                        we_d    = 1'b0;
                        state_d = S_WB;
                    end else begin
                        we_d    = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (dmem_ack) begin
                    if (we_q) begin
                        state_d = S_DONE;
                    end else begin
                        data_d  = dmem_rdata;
                        state_d = S_WB;
                    end
                end else begin
`ifdef LSU_WB_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == TO_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_WB:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with the state they describe.
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        req_d     = (state_d == S_REQ);
        mwe_d     = (state_d == S_REQ) && we_d;
        maddr_d   = (state_d == S_REQ) ? addr_d : 12'd0;
        mwdata_d  = ((state_d == S_REQ) && we_d) ? data_d : 32'd0;
        rfwe_d    = (state_d == S_WB) && (rd_d != 5'd0);
        rfwaddr_d = (state_d == S_WB) ? rd_d : 5'd0;
        rfwdata_d = (state_d == S_WB) ? data_d : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rd_q      <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            mwe_q     <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            rfwe_q    <= 1'b0;
            rfwaddr_q <= '0;
            rfwdata_q <= '0;
            err_q     <= 1'b0;
`ifdef LSU_WB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            req_q     <= req_d;
            mwe_q     <= mwe_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            rfwe_q    <= rfwe_d;
            rfwaddr_q <= rfwaddr_d;
            rfwdata_q <= rfwdata_d;
            err_q     <= err_d;
`ifdef LSU_WB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign dmem_req   = req_q;
    assign dmem_we    = mwe_q;
    assign dmem_addr  = maddr_q;
    assign dmem_wdata = mwdata_q;
    assign rf_we      = rfwe_q;
    assign rf_waddr   = rfwaddr_q;
    assign rf_wdata   = rfwdata_q;
    assign dbg_state  = state_q;
`ifdef LSU_WB_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb: ALU writeback, load, store, rd=0, busy/DONE start filtering, reset abort.
// Timeout scenario is included when LSU_WB_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=4).
module tb_lsu_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_l_instr;
    logic        is_s_instr;
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [11:0] alu_mem_addr;
    logic        busy;
    logic        done;
    logic        dmem_req;
    logic        dmem_we;
    logic [11:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [36:0] exp_q[$];

    lsu_wb #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .is_l_instr(is_l_instr), .is_s_instr(is_s_instr), .wr_en(wr_en),
        .rd(rd), .alu_result(alu_result), .alu_mem_addr(alu_mem_addr),
        .busy(busy), .done(done),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .err(err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge: outputs then show the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic l, input logic s, input logic w,
                               input logic [4:0] r, input logic [31:0] res, input logic [11:0] a);
        start = 1'b1; is_l_instr = l; is_s_instr = s; wr_en = w;
        rd = r; alu_result = res; alu_mem_addr = a;
    endtask

    task automatic idle_inputs();
        start = 1'b0; is_l_instr = 1'b0; is_s_instr = 1'b0; wr_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_req"},   32'(dmem_req), 32'd0);
        check({tag, "_we"},    32'(dmem_we), 32'd0);
        check({tag, "_addr"},  32'(dmem_addr), 32'd0);
        check({tag, "_wdata"}, dmem_wdata, 32'd0);
        check({tag, "_rfwe"},  32'(rf_we), 32'd0);
        check({tag, "_rfwa"},  32'(rf_waddr), 32'd0);
        check({tag, "_rfwd"},  rf_wdata, 32'd0);
        check({tag, "_err"},   32'(err), 32'd0);
    endtask

    // scoreboard: every register-file write must match the next expected {waddr, wdata}
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            if (exp_q.size() == 0) begin
                check("rf_unexpected_write", 32'(rf_we), 32'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("sb_waddr", 32'(rf_waddr), 32'(e[36:32]));
                check("sb_wdata", rf_wdata, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        rd = '0; alu_result = '0; alu_mem_addr = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // ALU writeback: rf_we at 1, done at 2
        drive_start(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 12'h3C0);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        step();
        idle_inputs();
        check("alu_c1_busy", 32'(busy), 32'd1);
        check("alu_c1_rfwe", 32'(rf_we), 32'd1);
        check("alu_c1_rfwa", 32'(rf_waddr), 32'd5);
        check("alu_c1_rfwd", rf_wdata, 32'hDEADBEEF);
        check("alu_c1_req",  32'(dmem_req), 32'd0);
        check("alu_c1_done", 32'(done), 32'd0);
        step();
        check("alu_c2_done", 32'(done), 32'd1);
        check("alu_c2_rfwe", 32'(rf_we), 32'd0);
        check("alu_c2_req",  32'(dmem_req), 32'd0);
        step();
        check("alu_c3_busy", 32'(busy), 32'd0);
        check("alu_c3_done", 32'(done), 32'd0);

        // Load with 3 wait cycles: req at 1..4, ack in cycle 4, rf_we at 5, done at 6
        drive_start(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0111, 12'h0A4);
        exp_q.push_back({5'd7, 32'h12345678});
        for (int c = 1; c <= 4; c++) begin
            step();
            idle_inputs();
            check($sformatf("ld_c%0d_req", c),  32'(dmem_req), 32'd1);
            check($sformatf("ld_c%0d_we", c),   32'(dmem_we), 32'd0);
            check($sformatf("ld_c%0d_addr", c), 32'(dmem_addr), 32'h0A4);
            check($sformatf("ld_c%0d_rfwe", c), 32'(rf_we), 32'd0);
            if (c == 4) begin
                dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
            end
        end
        step();
        dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
        check("ld_c5_req",  32'(dmem_req), 32'd0);
        check("ld_c5_rfwe", 32'(rf_we), 32'd1);
        check("ld_c5_rfwa", 32'(rf_waddr), 32'd7);
        check("ld_c5_rfwd", rf_wdata, 32'h12345678);
        check("ld_c5_done", 32'(done), 32'd0);
        step();
        check("ld_c6_done", 32'(done), 32'd1);
        check("ld_c6_rfwe", 32'(rf_we), 32'd0);
        step();
        check("ld_c7_busy", 32'(busy), 32'd0);

        // Store, ack on first REQ cycle: req at 1, done at 2, no rf_we
        drive_start(1'b0, 1'b1, 1'b0, 5'd9, 32'hCAFEF00D, 12'hFFF);
        step();
        idle_inputs();
        check("st_c1_req",   32'(dmem_req), 32'd1);
        check("st_c1_we",    32'(dmem_we), 32'd1);
        check("st_c1_addr",  32'(dmem_addr), 32'hFFF);
        check("st_c1_wdata", dmem_wdata, 32'hCAFEF00D);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("st_c2_req",  32'(dmem_req), 32'd0);
        check("st_c2_done", 32'(done), 32'd1);
        check("st_c2_rfwe", 32'(rf_we), 32'd0);
        step();
        check("st_c3_busy", 32'(busy), 32'd0);

        // Load and store both set: the load wins
        drive_start(1'b1, 1'b1, 1'b0, 5'd2, 32'h5555_AAAA, 12'h010);
        exp_q.push_back({5'd2, 32'h0BAD_CAFE});
        step();
        idle_inputs();
        check("lw_c1_req", 32'(dmem_req), 32'd1);
        check("lw_c1_we",  32'(dmem_we), 32'd0);
        check("lw_c1_wdata", dmem_wdata, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_CAFE;
        step();
        dmem_ack = 1'b0;
        check("lw_c2_rfwd", rf_wdata, 32'h0BAD_CAFE);
        step();
        check("lw_c3_done", 32'(done), 32'd1);
        step();

        // rd=0 with wr_en, start pulsed while busy and again during DONE
        drive_start(1'b0, 1'b0, 1'b1, 5'd0, 32'h1111_1111, 12'h000);
        step();
        check("r0_c1_busy", 32'(busy), 32'd1);
        check("r0_c1_rfwe", 32'(rf_we), 32'd0);
        drive_start(1'b1, 1'b0, 1'b1, 5'd9, 32'h2222_2222, 12'h123);
        step();
        check("r0_c2_done", 32'(done), 32'd1);
        check("r0_c2_req",  32'(dmem_req), 32'd0);
        drive_start(1'b0, 1'b0, 1'b1, 5'd4, 32'h3333_3333, 12'h000);
        step();
        idle_inputs();
        check("r0_c3_busy", 32'(busy), 32'd0);
        check("r0_c3_done", 32'(done), 32'd0);
        step();
        check("r0_c4_busy", 32'(busy), 32'd0);
        check("r0_c4_done", 32'(done), 32'd0);
        check("r0_c4_req",  32'(dmem_req), 32'd0);

        // Reset during REQ, then a stray ack
        drive_start(1'b1, 1'b0, 1'b1, 5'd3, 32'h0, 12'h055);
        step();
        idle_inputs();
        check("rr_c1_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("rr_async");
        step();
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
        step();
        dmem_ack = 1'b0;
        check("rr_stray_busy", 32'(busy), 32'd0);
        check("rr_stray_rfwe", 32'(rf_we), 32'd0);
        check("rr_stray_req",  32'(dmem_req), 32'd0);
        drive_start(1'b0, 1'b0, 1'b1, 5'd12, 32'hA5A5A5A5, 12'h000);
        exp_q.push_back({5'd12, 32'hA5A5A5A5});
        step();
        idle_inputs();
        check("rr_next_rfwe", 32'(rf_we), 32'd1);
        check("rr_next_rfwd", rf_wdata, 32'hA5A5A5A5);
        step();
        check("rr_next_done", 32'(done), 32'd1);
        step();

`ifdef LSU_WB_TIMEOUT_EN
        // Load that never acks: req 1..4, done at 5 with err, err sticky until next start
        drive_start(1'b1, 1'b0, 1'b1, 5'd6, 32'h0, 12'h200);
        for (int c = 1; c <= 4; c++) begin
            step();
            idle_inputs();
            check($sformatf("to_c%0d_req", c), 32'(dmem_req), 32'd1);
            check($sformatf("to_c%0d_err", c), 32'(err), 32'd0);
        end
        step();
        check("to_c5_req",  32'(dmem_req), 32'd0);
        check("to_c5_done", 32'(done), 32'd1);
        check("to_c5_err",  32'(err), 32'd1);
        check("to_c5_rfwe", 32'(rf_we), 32'd0);
        step();
        step();
        check("to_sticky_err", 32'(err), 32'd1);
        drive_start(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 12'h000);
        step();
        idle_inputs();
        check("to_clr_err",  32'(err), 32'd0);
        check("to_clr_done", 32'(done), 32'd1);
        step();
`else
        check("err_tied_low", 32'(err), 32'd0);
`endif

        step();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
